mii_tx_arbiter: RTL
===================

# mii_tx_arbiter

Transmit-side scheduler for the 64-bit/8-lane MII datapath. It shares one MII transmit lane between two packet sources using round-robin at frame boundaries. It frames each packet with a start word, payload and terminate, and enforces a minimum inter-packet gap of idle words. On a source underrun it emits an error sequence, so the downstream `mii_checker_sm` sees only legal idle/start/data/terminate/error words.

## Interface
- `MIN_IPG_WORDS`, default 2: full idle words (`0x0707070707070707`, ctrl `0xFF`) required after a terminate before the next start.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits new grants; a frame in progress always completes.
- `s0_valid`, `s1_valid`  in  1  source word available.
- `s0_ready`, `s1_ready`  out  1  word consumed on `valid & ready`.
- `s0_data`, `s1_data`  in  64  payload; byte 0 = bits [7:0] = first on wire.
- `s0_last`, `s1_last`  in  1  final word of frame.
- `s0_bytes`, `s1_bytes`  in  4  valid bytes on last word, 1..8; 0 is treated as 8; ignored when not last.
- `mii_data_out`  out  64  registered MII data.
- `mii_ctrl_out`  out  8  registered MII control; bit n flags lane n as a control character.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `grant_id`  out  1  source of the current or most recent frame.
- `frame_count`  out  16  frames completed with a normal terminate; wraps.
- `underrun_count`  out  8  underruns; saturates at 255.

## Operation
- States: IDLE, DATA, TERM, DRAIN. Output registers and state update on the same edge.
- **IDLE**
  - Loads the idle word and increments `ipg_cnt` (saturating at `MIN_IPG_WORDS`).
  - A grant is allowed when `enable` is high, `ipg_cnt ≥ MIN_IPG_WORDS`, and any `sN_valid` is high.
  - On a grant: load the start word `0x55555555555555FB`, ctrl `0x01`, instead of idle. Set `grant_id`, update `last_grant`, go to DATA.
  - Round robin: if both sources are valid, grant the source ≠ `last_grant`; otherwise grant the only valid source.
- **DATA**
  - The granted `sN_ready` is high; the other ready is low.
  - `valid` and not `last`: load data, ctrl `0x00`.
  - `valid`, `last`, k < 8:
    - lanes 0..k-1 carry data, lane k = `FD`, lanes k+1..7 = `07`;
    - ctrl = `8'hFF << k`;
    - `frame_count++`, `ipg_cnt` ← 0, go to IDLE.
  - `valid`, `last`, k = 8: load data, ctrl `0x00`, go to TERM.
  - `valid` low (underrun): load `0xFEFEFEFEFEFEFEFE`, ctrl `0xFF`. Set `drain_flag`, `underrun_count++`, go to TERM.
- **TERM**
  - Ready is low.
  - Load `0x07070707070707FD`, ctrl `0xFF`; `ipg_cnt` ← 0.
  - If `drain_flag`: go to DRAIN.
  - Otherwise: `frame_count++`, go to IDLE.
- **DRAIN**
  - The granted ready is high; words are discarded.
  - Load idle; `ipg_cnt` increments.
  - On `valid & last`: clear `drain_flag`, go to IDLE.

## Timing
- Reset values:
  - outputs: `mii_data_out` = `0x0707070707070707`, `mii_ctrl_out` = `0xFF`; both readies 0; `busy` 0; `grant_id` 0; both counters 0;
  - internal: `last_grant` = 1 (so s0 wins the first tie); `ipg_cnt` = `MIN_IPG_WORDS`; `drain_flag` 0; state IDLE.
- Latency:
  - The start word appears on the edge that samples the request.
  - First payload is consumed the following cycle and appears one edge later.
  - Each accepted word appears on the edge of acceptance (1-cycle registered).
- Readies are combinational from state and `grant_id` only; they never depend on `valid`.
- `enable` falling mid-frame has no effect until IDLE.
- Reset mid-frame aborts without terminate; the output returns to idle on the next edge.
- A source asserting `valid` in IDLE while the gap is not met is held off with ready low.
- The non-granted source's `last` and `bytes` are ignored.

## Structure
- Shared package `mii_pkg` holds:
  - character constants: `MII_IDLE` 0x07, `MII_START` 0xFB, `MII_TERM` 0xFD, `MII_ERROR` 0xFE, `MII_PREAMBLE` 0x55;
  - the full idle, start and error word constants;
  - the state enum.
- Sub-module `mii_term_encoder`: combinational; (data, k) → merged terminate data and ctrl. Reusable by the checker's reference model.

## Test plan
- **Single frame:** s0 sends 20 words of `0x1111111111111111`, last k=3 `0x0000000000000000` → start `55555555555555FB`/`01`, 20 data/`00`, then `07070707FD000000`/`F8`, then idle; `frame_count` = 1.
- **Full last word:** k=8 → data/`00` then `07070707070707FD`/`FF`; no further data words.
- **Contention:** both valid in IDLE after reset → s0 granted first, s1 next. Between them, ≥ `MIN_IPG_WORDS` (2) idle words follow the terminate.
- **Underrun:** s1 drops valid in the 5th word → `FEFE…FE`/`FF`, then `07…07FD`/`FF`. Remaining s1 words are consumed while idles are emitted. `underrun_count` = 1, `frame_count` unchanged.
- **Gating:** `enable` low with s0 valid → continuous idle, `s0_ready` 0. Deasserting `enable` mid-frame still completes that frame with terminate.
- **Reset mid-DATA:** the next output is idle/`FF`; `busy` = 0 and counters = 0.

Source files
------------

// File: rtl/mii_pkg.sv
// Shared MII character and word constants plus the transmit scheduler state type.
// Imported by the arbiter, its terminate encoder and the checker's reference model.
package mii_pkg;

  localparam logic [7:0] MII_IDLE     = 8'h07;
  localparam logic [7:0] MII_START    = 8'hFB;
  localparam logic [7:0] MII_TERM     = 8'hFD;
  localparam logic [7:0] MII_ERROR    = 8'hFE;
  localparam logic [7:0] MII_PREAMBLE = 8'h55;

  localparam logic [63:0] MII_IDLE_WORD  = {8{MII_IDLE}};
  localparam logic [63:0] MII_START_WORD = {{7{MII_PREAMBLE}}, MII_START};
  localparam logic [63:0] MII_ERROR_WORD = {8{MII_ERROR}};
  localparam logic [63:0] MII_TERM_WORD  = {{7{MII_IDLE}}, MII_TERM};

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StTerm,
    StDrain
  } tx_state_e;

  // A byte count of 0 (or anything out of range) means a full 8-byte word.
  function automatic logic [3:0] norm_bytes(logic [3:0] b);
    return ((b == 4'd0) || (b > 4'd8)) ? 4'd8 : b;
  endfunction

endpackage

// File: rtl/mii_tx_arbiter_if.sv
// Source handshakes, MII transmit lane and status of the two-source transmit arbiter.
interface mii_tx_arbiter_if;

  logic        enable;
  logic        s0_valid;
  logic        s0_ready;
  logic [63:0] s0_data;
  logic        s0_last;
  logic [3:0]  s0_bytes;
  logic        s1_valid;
  logic        s1_ready;
  logic [63:0] s1_data;
  logic        s1_last;
  logic [3:0]  s1_bytes;
  logic [63:0] mii_data_out;
  logic [7:0]  mii_ctrl_out;
  logic        busy;
  logic        grant_id;
  logic [15:0] frame_count;
  logic [7:0]  underrun_count;

  modport master (
    output enable, s0_valid, s0_data, s0_last, s0_bytes,
    output s1_valid, s1_data, s1_last, s1_bytes,
    input  s0_ready, s1_ready, mii_data_out, mii_ctrl_out,
    input  busy, grant_id, frame_count, underrun_count
  );

  modport slave (
    input  enable, s0_valid, s0_data, s0_last, s0_bytes,
    input  s1_valid, s1_data, s1_last, s1_bytes,
    output s0_ready, s1_ready, mii_data_out, mii_ctrl_out,
    output busy, grant_id, frame_count, underrun_count
  );

endinterface

// File: rtl/mii_term_encoder.sv
// Merges a partial last payload word with the terminate character: lanes below k keep
// data, lane k carries the terminate, higher lanes idle. k >= 8 passes the word through.
module mii_term_encoder
  import mii_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [3:0]  k_i,
  output logic [63:0] data_o,
  output logic [7:0]  ctrl_o
);

  always_comb begin
    data_o = '0;
    ctrl_o = '0;
    for (int unsigned l = 0; l < 8; l++) begin
      if (4'(l) < k_i) begin
        data_o[8*l +: 8] = data_i[8*l +: 8];
      end else if (4'(l) == k_i) begin
        data_o[8*l +: 8] = MII_TERM;
        ctrl_o[l]        = 1'b1;
      end else begin
        data_o[8*l +: 8] = MII_IDLE;
        ctrl_o[l]        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mii_tx_arbiter.sv
// Shares one 64-bit MII transmit lane between two packet sources, round-robin at frame
// boundaries, framing each packet and enforcing a minimum idle gap between frames.
module mii_tx_arbiter
  import mii_pkg::*;
#(
  parameter int unsigned MIN_IPG_WORDS = 2
) (
  input logic             clk,
  input logic             rst,
  mii_tx_arbiter_if.slave bus
);

  localparam int unsigned IpgW = (MIN_IPG_WORDS < 1) ? 1 : $clog2(MIN_IPG_WORDS + 1);
  localparam logic [IpgW-1:0] IpgMin = IpgW'(MIN_IPG_WORDS);

  tx_state_e        state_q, state_d;
  logic [63:0]      data_q, data_d;
  logic [7:0]       ctrl_q, ctrl_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [IpgW-1:0]  ipg_q, ipg_d, ipg_inc;
  logic             drain_q, drain_d;
  logic [15:0]      frame_q, frame_d;
  logic [7:0]       under_q, under_d;

  logic        sel_valid, sel_last, src_ready;
  logic [63:0] sel_data, term_data;
  logic [3:0]  sel_k;
  logic [7:0]  term_ctrl;

  assign sel_valid = grant_q ? bus.s1_valid : bus.s0_valid;
  assign sel_last  = grant_q ? bus.s1_last  : bus.s0_last;
  assign sel_data  = grant_q ? bus.s1_data  : bus.s0_data;
  assign sel_k     = norm_bytes(grant_q ? bus.s1_bytes : bus.s0_bytes);
  assign ipg_inc   = (ipg_q >= IpgMin) ? IpgMin : ipg_q + IpgW'(1);

  mii_term_encoder u_term (
    .data_i (sel_data),
    .k_i    (sel_k),
    .data_o (term_data),
    .ctrl_o (term_ctrl)
  );

  always_comb begin
    state_d      = state_q;
    data_d       = MII_IDLE_WORD;
    ctrl_d       = 8'hFF;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ipg_d        = ipg_q;
    drain_d      = drain_q;
    frame_d      = frame_q;
    under_d      = under_q;
    unique case (state_q)
      StIdle: begin
        ipg_d = ipg_inc;
        if (bus.enable && (ipg_q >= IpgMin) && (bus.s0_valid || bus.s1_valid)) begin
          // On a tie the source that did not win last time goes next.
          grant_d      = (bus.s0_valid && bus.s1_valid) ? ~last_grant_q : bus.s1_valid;
          last_grant_d = grant_d;
          data_d       = MII_START_WORD;
          ctrl_d       = 8'h01;
          state_d      = StData;
        end
      end
      StData: begin
        if (sel_valid) begin
          data_d = sel_data;
          ctrl_d = 8'h00;
          if (sel_last) begin
            if (sel_k == 4'd8) begin
              state_d = StTerm;
            end else begin
              data_d  = term_data;
              ctrl_d  = term_ctrl;
              frame_d = frame_q + 16'd1;
              ipg_d   = '0;
              state_d = StIdle;
            end
          end
        end else begin
          data_d  = MII_ERROR_WORD;
          drain_d = 1'b1;
          under_d = (under_q == 8'hFF) ? under_q : under_q + 8'd1;
          state_d = StTerm;
        end
      end
      StTerm: begin
        data_d = MII_TERM_WORD;
        ipg_d  = '0;
        if (drain_q) begin
          state_d = StDrain;
        end else begin
          frame_d = frame_q + 16'd1;
          state_d = StIdle;
        end
      end
      StDrain: begin
        // Discard the rest of the aborted frame while idling.
        ipg_d = ipg_inc;
        if (sel_valid && sel_last) begin
          drain_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      data_q       <= MII_IDLE_WORD;
      ctrl_q       <= 8'hFF;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ipg_q        <= IpgMin;
      drain_q      <= 1'b0;
      frame_q      <= '0;
      under_q      <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      ctrl_q       <= ctrl_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ipg_q        <= ipg_d;
      drain_q      <= drain_d;
      frame_q      <= frame_d;
      under_q      <= under_d;
    end
  end

  assign src_ready          = (state_q == StData) || (state_q == StDrain);
  assign bus.s0_ready       = src_ready & ~grant_q;
  assign bus.s1_ready       = src_ready & grant_q;
  assign bus.mii_data_out   = data_q;
  assign bus.mii_ctrl_out   = ctrl_q;
  assign bus.busy           = (state_q != StIdle);
  assign bus.grant_id       = grant_q;
  assign bus.frame_count    = frame_q;
  assign bus.underrun_count = under_q;

endmodule
